// File: rtl/link_pkg.sv
// Shared definitions for the round-robin link scheduler and its arbiter:
// source count, field widths, FSM state type and destination codes.
package link_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DEST_W  = 2;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STAT_W  = 8;

    // Destination codes understood by the downstream demux.
    localparam logic [DEST_W-1:0] DEST_LIB    = 2'b00;
    localparam logic [DEST_W-1:0] DEST_FD     = 2'b01;
    localparam logic [DEST_W-1:0] DEST_SCHOOL = 2'b10;
    localparam logic [DEST_W-1:0] DEST_RIBS   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin picker.
// Ports:
//   valid     - per-source request
//   pointer   - index of the last winner; search starts at pointer+1
//   any_valid - at least one request present
//   winner    - index of the selected source (0 when no request)
//   onehot    - one-hot form of winner (all zero when no request)
module rr_arbiter4
    import link_pkg::*;
(
    input  logic [NUM_SRC-1:0] valid,
    input  logic [IDX_W-1:0]   pointer,
    output logic               any_valid,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_SRC-1:0] onehot
);

    // Walk pointer+1 .. pointer+4; the 2-bit add wraps modulo 4.
    always_comb begin
        logic [IDX_W-1:0] idx;
        any_valid = 1'b0;
        winner    = '0;
        idx       = pointer;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = pointer + IDX_W'(k);
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
        onehot = any_valid ? (NUM_SRC'(1) << winner) : '0;
    end

endmodule

// File: rtl/rr_link_scheduler.sv
// Round-robin scheduler feeding the 4-way destination demux. Grants one
// requesting source at a time and drives mux_output/enable/sel for
// HOLD_CYCLES cycles per transfer; the last hold cycle can accept the next
// request so back-to-back transfers have no enable gap.
// Optional: define RR_LINK_SCHEDULER_STATS_EN to add grant_count, four
// saturating 8-bit per-source acceptance counters.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   src_data    - packed source words, source i at [i*DATA_W +: DATA_W]
//   src_dest    - packed destination codes, source i at [2i +: 2]
//   src_valid   - per-source request
//   src_ready   - one-hot acceptance pulse, high in the accepting cycle
//   mux_output  - registered data toward demux
//   enable      - high while a transfer is driven
//   sel         - registered destination code toward demux
//   grant_src   - index of the source being sent
//   busy        - high in SEND
//   grant_count - (stats build only) counter i at [8i +: 8]
module rr_link_scheduler
    import link_pkg::*;
#(
    parameter int unsigned DATA_W      = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC*DEST_W-1:0]   src_dest,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [DATA_W-1:0]           mux_output,
    output logic                        enable,
    output logic [DEST_W-1:0]           sel,
    output logic [IDX_W-1:0]            grant_src,
    output logic                        busy
`ifdef RR_LINK_SCHEDULER_STATS_EN
    ,
    output logic [NUM_SRC*STAT_W-1:0]   grant_count
`endif
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mux_q, mux_d;
    logic [DEST_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]    grant_q, grant_d;

    logic                arb_any;
    logic [IDX_W-1:0]    arb_winner;
    logic [NUM_SRC-1:0]  arb_onehot;
    logic                accept_c;

    rr_arbiter4 u_arb (
        .valid     (src_valid),
        .pointer   (ptr_q),
        .any_valid (arb_any),
        .winner    (arb_winner),
        .onehot    (arb_onehot)
    );

    // Next-state logic: accept in IDLE or on the last SEND cycle, else count down.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        mux_d    = mux_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        accept_c = 1'b0;

        if (rst_n && arb_any && ((state_q == IDLE) || (cnt_q == '0))) begin
            accept_c = 1'b1;
            state_d  = SEND;
            ptr_d    = arb_winner;
            cnt_d    = CNT_W'(HOLD_CYCLES - 1);
            grant_d  = arb_winner;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (arb_winner == IDX_W'(i)) begin
                    mux_d = src_data[i*DATA_W +: DATA_W];
                    sel_d = src_dest[i*DEST_W +: DEST_W];
                end
            end
        end else if (state_q == SEND) begin
            if (cnt_q == '0) begin
                // Transfer done with nobody waiting: sel keeps its last code.
                state_d = IDLE;
                mux_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_SRC - 1);
            cnt_q   <= '0;
            mux_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mux_q   <= mux_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    // Ready must be seen by the source in the same cycle it is accepted.
    assign src_ready  = accept_c ? arb_onehot : '0;
    assign mux_output = mux_q;
    assign sel        = sel_q;
    assign grant_src  = grant_q;
    assign enable     = (state_q == SEND);
    assign busy       = (state_q == SEND);

`ifdef RR_LINK_SCHEDULER_STATS_EN
    logic [NUM_SRC*STAT_W-1:0] stat_q, stat_d;

    // Saturating per-source acceptance counters.
    always_comb begin
        stat_d = stat_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i] && (stat_q[i*STAT_W +: STAT_W] != '1)) begin
                stat_d[i*STAT_W +: STAT_W] = stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign grant_count = stat_q;
`endif

endmodule

// File: tb/tb_rr_link_scheduler.sv
// Self-checking bench: two schedulers (HOLD_CYCLES=4 and 1) driven by
// directed and random request streams, compared each cycle to a
// transfer-level model (pointer, remaining enable cycles, held word).
module tb_rr_link_scheduler;
    import link_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] s_data  [2];
    logic [7:0]  s_dest  [2];
    logic [3:0]  s_valid [2];
    logic [3:0]  o_ready [2];
    logic [3:0]  o_mux   [2];
    logic        o_en    [2];
    logic        o_busy  [2];
    logic [1:0]  o_sel   [2];
    logic [1:0]  o_grant [2];
`ifdef RR_LINK_SCHEDULER_STATS_EN
    logic [31:0] o_gc    [2];
`endif

    rr_link_scheduler #(.DATA_W(4), .HOLD_CYCLES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .src_data(s_data[0]), .src_dest(s_dest[0]),
        .src_valid(s_valid[0]), .src_ready(o_ready[0]), .mux_output(o_mux[0]),
        .enable(o_en[0]), .sel(o_sel[0]), .grant_src(o_grant[0]), .busy(o_busy[0])
`ifdef RR_LINK_SCHEDULER_STATS_EN
        , .grant_count(o_gc[0])
`endif
    );

    rr_link_scheduler #(.DATA_W(4), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .src_data(s_data[1]), .src_dest(s_dest[1]),
        .src_valid(s_valid[1]), .src_ready(o_ready[1]), .mux_output(o_mux[1]),
        .enable(o_en[1]), .sel(o_sel[1]), .grant_src(o_grant[1]), .busy(o_busy[1])
`ifdef RR_LINK_SCHEDULER_STATS_EN
        , .grant_count(o_gc[1])
`endif
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_on = 1'b0;
    logic [3:0]  seen [2];

    // Model state: last winner, enable cycles still to show, held outputs.
    int          m_ptr  [2];
    int          m_left [2];
    logic [3:0]  m_mux  [2];
    logic [1:0]  m_sel  [2];
    logic [1:0]  m_grant[2];
    int          m_cnt  [2][4];

    function automatic int hold_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Source accepted this cycle by instance u (-1 when none).
    function automatic int acc_of(input int u);
        if (rst_n !== 1'b1) return -1;
        if (m_left[u] > 1) return -1;
        return pick(s_valid[u], m_ptr[u]);
    endfunction

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, u, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        int w;
        for (int u = 0; u < 2; u++) begin
            w = acc_of(u);
            if (rst_n !== 1'b1) begin
                m_ptr[u]   <= 3;
                m_left[u]  <= 0;
                m_mux[u]   <= '0;
                m_sel[u]   <= '0;
                m_grant[u] <= '0;
                for (int i = 0; i < 4; i++) m_cnt[u][i] <= 0;
            end else if (w >= 0) begin
                m_ptr[u]   <= w;
                m_left[u]  <= hold_of(u);
                m_mux[u]   <= s_data[u][w*4 +: 4];
                m_sel[u]   <= s_dest[u][w*2 +: 2];
                m_grant[u] <= 2'(w);
                if (m_cnt[u][w] < 255) m_cnt[u][w] <= m_cnt[u][w] + 1;
            end else if (m_left[u] > 0) begin
                m_left[u] <= m_left[u] - 1;
                if (m_left[u] == 1) m_mux[u] <= '0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        for (int u = 0; u < 2; u++) begin
            seen[u] = o_ready[u];
            if (chk_on) begin
                w = acc_of(u);
                chk("ready", u, 32'(o_ready[u]), (w >= 0) ? 32'(1 << w) : 32'd0);
                chk("ready_onehot", u, 32'($countones(o_ready[u]) <= 1), 32'd1);
                chk("ready_vs_valid", u, 32'(o_ready[u] & ~s_valid[u]), 32'd0);
                chk("enable", u, 32'(o_en[u]), 32'(m_left[u] > 0));
                chk("busy", u, 32'(o_busy[u]), 32'(m_left[u] > 0));
                chk("mux_output", u, 32'(o_mux[u]), 32'(m_mux[u]));
                chk("sel", u, 32'(o_sel[u]), 32'(m_sel[u]));
                if (m_left[u] > 0) chk("grant_src", u, 32'(o_grant[u]), 32'(m_grant[u]));
`ifdef RR_LINK_SCHEDULER_STATS_EN
                for (int i = 0; i < 4; i++)
                    chk("grant_count", u, 32'(o_gc[u][i*8 +: 8]), 32'(m_cnt[u][i]));
`endif
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = '0; s_data[u] = '0; s_dest[u] = '0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = '0; s_data[u] = '0; s_dest[u] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_enable", 0, 32'(o_en[0]), 32'd0);
        chk("reset_grant", 0, 32'(o_grant[0]), 32'd0);

        // Single transfer from source 0 to SCHOOL.
        do_reset();
        s_valid[0] = 4'b0001; s_data[0] = 16'h000A; s_dest[0] = {6'b0, DEST_SCHOOL};
        @(negedge clk);
        chk("t1_ready", 0, 32'(o_ready[0]), 32'h1);
        @(posedge clk); #1;
        s_valid[0] = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t1_enable", 0, 32'(o_en[0]), 32'd1);
            chk("t1_mux", 0, 32'(o_mux[0]), 32'hA);
            chk("t1_sel", 0, 32'(o_sel[0]), 32'h2);
            chk("t1_grant", 0, 32'(o_grant[0]), 32'h0);
        end
        @(negedge clk);
        chk("t1_end_enable", 0, 32'(o_en[0]), 32'd0);
        chk("t1_end_mux", 0, 32'(o_mux[0]), 32'd0);

        // All four requesting continuously, data 1/2/3/4.
        do_reset();
        s_valid[0] = 4'b1111; s_data[0] = 16'h4321; s_dest[0] = 8'b11100100;
        @(negedge clk);
        chk("t2_first_ready", 0, 32'(o_ready[0]), 32'h1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("t2_enable", 0, 32'(o_en[0]), 32'd1);
            chk("t2_grant", 0, 32'(o_grant[0]), 32'(((c - 1) / 4) % 4));
            chk("t2_mux", 0, 32'(o_mux[0]), 32'(((c - 1) / 4) % 4 + 1));
            chk("t2_ready", 0, 32'(o_ready[0]), (c % 4 == 0) ? 32'(1 << ((c / 4) % 4)) : 32'd0);
        end
        @(posedge clk); #1;
        s_valid[0] = '0;
        repeat (5) @(posedge clk);
        #1;

        // HOLD_CYCLES=1 with sources 1 and 3 requesting.
        do_reset();
        s_valid[1] = 4'b1010; s_data[1] = 16'h7050; s_dest[1] = 8'b01000100;
        @(negedge clk);
        chk("t3_first_ready", 1, 32'(o_ready[1]), 32'h2);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("t3_enable", 1, 32'(o_en[1]), 32'd1);
            chk("t3_grant", 1, 32'(o_grant[1]), (c % 2 == 1) ? 32'd1 : 32'd3);
            chk("t3_ready", 1, 32'(o_ready[1]), (c % 2 == 1) ? 32'h8 : 32'h2);
        end
        @(posedge clk); #1;
        s_valid[1] = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during the second SEND cycle; source 0 must win again afterwards.
        do_reset();
        s_valid[0] = 4'b0001; s_data[0] = 16'h0005; s_dest[0] = 8'h03;
        @(negedge clk);
        chk("t4_ready", 0, 32'(o_ready[0]), 32'h1);
        @(posedge clk); #1;
        s_valid[0] = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_valid[0] = 4'b1111; s_data[0] = 16'h4321;
        @(negedge clk);
        chk("t4_rst_enable", 0, 32'(o_en[0]), 32'd0);
        chk("t4_rst_mux", 0, 32'(o_mux[0]), 32'd0);
        chk("t4_rst_sel", 0, 32'(o_sel[0]), 32'd0);
        chk("t4_rst_grant", 0, 32'(o_grant[0]), 32'd0);
        chk("t4_rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("t4_src0_wins", 0, 32'(o_ready[0]), 32'h1);
        @(posedge clk); #1;
        s_valid[0] = '0;
        repeat (5) @(posedge clk);
        #1;

        // Source 2 drops valid after acceptance: full transfer, no extra ready.
        do_reset();
        s_valid[0] = 4'b0100; s_data[0] = 16'h0C00; s_dest[0] = 8'h10;
        @(negedge clk);
        chk("t5_ready", 0, 32'(o_ready[0]), 32'h4);
        @(posedge clk); #1;
        s_valid[0] = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("t5_enable", 0, 32'(o_en[0]), 32'd1);
            chk("t5_grant", 0, 32'(o_grant[0]), 32'd2);
            chk("t5_no_ready", 0, 32'(o_ready[0]), 32'd0);
        end
        repeat (3) begin
            @(negedge clk);
            chk("t5_idle", 0, 32'(o_en[0]), 32'd0);
            chk("t5_idle_sel", 0, 32'(o_sel[0]), 32'd1);
        end

        // Random requests with occasional reset, both instances.
        do_reset();
        repeat (3000) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 4; i++) begin
                    if (seen[u][i]) begin
                        s_valid[u][i]      = 1'($urandom_range(0, 1));
                        s_data[u][i*4 +: 4] = 4'($urandom);
                        s_dest[u][i*2 +: 2] = 2'($urandom);
                    end else if (!s_valid[u][i] && $urandom_range(0, 2) == 0) begin
                        s_valid[u][i]      = 1'b1;
                        s_data[u][i*4 +: 4] = 4'($urandom);
                        s_dest[u][i*2 +: 2] = 2'($urandom);
                    end
                end
            end
        end

        // Long run from source 1 alone on the HOLD_CYCLES=1 instance.
        do_reset();
        s_valid[1] = 4'b0010; s_data[1] = 16'h0090; s_dest[1] = 8'h04;
        repeat (310) @(posedge clk);
        #1;
        s_valid[1] = '0;
        @(negedge clk);
`ifdef RR_LINK_SCHEDULER_STATS_EN
        chk("stats_src1_sat", 1, 32'(o_gc[1][15:8]), 32'd255);
        chk("stats_others", 1, {o_gc[1][31:16], o_gc[1][7:0]}, 32'd0);
`endif
        chk("long_run_last_grant", 1, 32'(o_grant[1]), 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
